// File: rtl/task_pkg.sv
// Shared types and constants for the task node controller.
// Op word layout: [15:12] reserved, [11:8] address, [7:4] opcode, [3:0] argument.
package task_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_SUSP  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_TERM  = 2'b11
  } state_e;

  localparam logic [3:0] OPC_READY    = 4'h1;
  localparam logic [3:0] OPC_SUSPEND  = 4'h2;
  localparam logic [3:0] OPC_WAIT     = 4'h3;
  localparam logic [3:0] OPC_KILL     = 4'h4;
  localparam logic [3:0] OPC_SET_PRIO = 4'h5;
  localparam logic [3:0] OPC_ADD_HIT  = 4'h6;
  localparam logic [3:0] OPC_EXEC     = 4'h7;
  localparam logic [3:0] OPC_KILL_ALL = 4'hC;

  localparam int OP_RSVD_LSB = 12;
  localparam int OP_ADDR_LSB = 8;
  localparam int OP_OPC_LSB  = 4;
  localparam int OP_ARG_LSB  = 0;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] addr;
    logic [3:0] opcode;
    logic [3:0] arg;
  } op_t;

  function automatic op_t op_unpack(input logic [15:0] word);
    op_t o;
    o.rsvd   = word[OP_RSVD_LSB +: 4];
    o.addr   = word[OP_ADDR_LSB +: 4];
    o.opcode = word[OP_OPC_LSB  +: 4];
    o.arg    = word[OP_ARG_LSB  +: 4];
    return o;
  endfunction

endpackage

// File: rtl/task_node_fsm.sv
// Per-node task state machine: state, priority and optional aging counter.
// Optional feature macro: TASK_AGING_EN (adds the priority-aging counter).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_READY | node may execute; out_mcu shows {priority, TASK_ID}
// ST_SUSP  | node suspended; out_mcu reads 0
// ST_WAIT  | node waiting; out_mcu reads 0
// ST_TERM  | terminated; absorbing until reset, all ops ignored
module task_node_fsm
  import task_pkg::*;
#(
  parameter logic [3:0] TASK_ID    = 4'h2,
  parameter int         PRIO_W     = 4,
  parameter int         AGE_PERIOD = 10000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [15:0]       i_op,
  input  logic              i_valid,
  input  logic              i_kill_all,
  input  logic              i_grant,
  output logic [PRIO_W-1:0] o_prio,
  output state_e            o_state_nxt,
  output logic [PRIO_W-1:0] o_prio_nxt,
  output logic              o_exec_req,
  output logic              o_kill_req,
  output logic [3:0]        o_add_arg
);

  localparam logic [PRIO_W-1:0] PRIO_MAX = '1;

  op_t               w_op;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [PRIO_W-1:0] r_prio;
  logic [PRIO_W-1:0] w_prio_nxt;
  logic              w_live;
  logic              w_age_tick;
  logic              w_unused;

  assign w_op       = op_unpack(i_op);
  // A terminated node's ops decode to nothing
  assign w_live     = i_valid && (w_op.addr == TASK_ID) && (r_state != ST_TERM);
  assign o_exec_req = w_live && (w_op.opcode == OPC_EXEC) && (r_state == ST_READY);
  assign o_kill_req = w_live && (w_op.opcode == OPC_KILL_ALL);
  assign o_add_arg  = (w_live && (w_op.opcode == OPC_ADD_HIT)) ? w_op.arg : 4'h0;

  assign o_prio      = r_prio;
  assign o_state_nxt = w_state_nxt;
  assign o_prio_nxt  = w_prio_nxt;

`ifdef TASK_AGING_EN
  localparam int               CNT_W    = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(AGE_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Aging counter advances only while Ready; a grant restarts the period
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_age_tick = 1'b0;
    if (r_state == ST_READY) begin
      if (r_cnt == CNT_WRAP) begin
        w_cnt_nxt  = '0;
        w_age_tick = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
    if (i_grant) w_cnt_nxt = '0;
  end

  // Aging counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign w_unused = ^w_op.rsvd;
`else
  assign w_age_tick = 1'b0;
  assign w_unused   = ^{w_op.rsvd, i_grant, AGE_PERIOD[0]};
`endif

  // Next state / priority; kill-all wins, op 5 overrides an aging step
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    if (w_age_tick && (r_prio != PRIO_MAX)) w_prio_nxt = r_prio + 1'b1;
    if (i_kill_all) begin
      w_state_nxt = ST_TERM;
    end else if (w_live) begin
      case (w_op.opcode)
        OPC_READY:    w_state_nxt = ST_READY;
        OPC_SUSPEND:  w_state_nxt = ST_SUSP;
        OPC_WAIT:     w_state_nxt = ST_WAIT;
        OPC_KILL:     w_state_nxt = ST_TERM;
        OPC_SET_PRIO: w_prio_nxt  = PRIO_W'(w_op.arg);
        default:      ;
      endcase
    end
  end

  // State and priority registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_READY;
      r_prio  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

endmodule

// File: rtl/task_node_ctrl.sv
// Task controller shared by N_NODES MCU nodes: execute arbiter, shared
// hit budget and registered per-node scheduler outputs.
// Optional feature macro: TASK_AGING_EN (per-node priority aging, in task_node_fsm).
module task_node_ctrl
  import task_pkg::*;
#(
  parameter int         N_NODES    = 2,
  parameter logic [3:0] TASK_ID    = 4'h2,
  parameter int         PRIO_W     = 4,
  parameter int         HIT_W      = 8,
  parameter int         HIT_INIT   = 128,
  parameter int         AGE_PERIOD = 10000
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [16*N_NODES-1:0]          in_op,
  input  logic [N_NODES-1:0]             in_op_valid,
  output logic [(PRIO_W+4)*N_NODES-1:0]  out_mcu,
  output logic [N_NODES-1:0]             exe_grant,
  output logic [HIT_W-1:0]               hit_left
);

  localparam int               OUT_W   = PRIO_W + 4;
  localparam int               SUM_W   = HIT_W + 8;
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  logic [PRIO_W-1:0]          w_prio     [N_NODES];
  logic [PRIO_W-1:0]          w_prio_nxt [N_NODES];
  state_e                     w_state_nxt[N_NODES];
  logic [3:0]                 w_add_arg  [N_NODES];
  logic [N_NODES-1:0]         w_exec_req;
  logic [N_NODES-1:0]         w_kill_req;
  logic [N_NODES-1:0]         w_grant;
  logic                       w_kill_all;
  logic                       w_found;
  logic [PRIO_W-1:0]          w_best;
  logic [SUM_W-1:0]           w_sum;
  logic [HIT_W-1:0]           w_hit_nxt;
  logic [OUT_W*N_NODES-1:0]   w_out_nxt;
  logic [OUT_W*N_NODES-1:0]   r_out;
  logic [N_NODES-1:0]         r_grant;
  logic [HIT_W-1:0]           r_hit;

  for (genvar g = 0; g < N_NODES; g++) begin : g_node
    task_node_fsm #(
      .TASK_ID   (TASK_ID),
      .PRIO_W    (PRIO_W),
      .AGE_PERIOD(AGE_PERIOD)
    ) u_node (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .i_op       (in_op[16*g +: 16]),
      .i_valid    (in_op_valid[g]),
      .i_kill_all (w_kill_all),
      .i_grant    (w_grant[g]),
      .o_prio     (w_prio[g]),
      .o_state_nxt(w_state_nxt[g]),
      .o_prio_nxt (w_prio_nxt[g]),
      .o_exec_req (w_exec_req[g]),
      .o_kill_req (w_kill_req[g]),
      .o_add_arg  (w_add_arg[g])
    );
  end

  assign w_kill_all = |w_kill_req;

  // Single grant: highest priority wins, strict compare keeps the lowest index on ties
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_best  = '0;
    for (int n = 0; n < N_NODES; n++) begin
      if (w_exec_req[n] && (!w_found || (w_prio[n] > w_best))) begin
        w_grant    = '0;
        w_grant[n] = 1'b1;
        w_found    = 1'b1;
        w_best     = w_prio[n];
      end
    end
    if (w_kill_all || (r_hit == '0)) w_grant = '0;
  end

  // Budget: add all op-6 args, take one per grant, clamp at the top
  always_comb begin
    w_sum = SUM_W'(r_hit);
    for (int n = 0; n < N_NODES; n++) w_sum = w_sum + SUM_W'(w_add_arg[n]);
    if (|w_grant) w_sum = w_sum - SUM_W'(1);
    w_hit_nxt = (w_sum > SUM_W'(HIT_MAX)) ? HIT_MAX : w_sum[HIT_W-1:0];
    if (w_kill_all) w_hit_nxt = r_hit;
  end

  // Scheduler word per node, taken from the state being entered this edge
  always_comb begin
    w_out_nxt = '0;
    for (int n = 0; n < N_NODES; n++) begin
      if (w_state_nxt[n] == ST_READY) w_out_nxt[n*OUT_W +: OUT_W] = {w_prio_nxt[n], TASK_ID};
    end
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out   <= '0;
      r_grant <= '0;
      r_hit   <= HIT_W'(HIT_INIT);
    end else begin
      r_out   <= w_out_nxt;
      r_grant <= w_grant;
      r_hit   <= w_hit_nxt;
    end
  end

  assign out_mcu   = r_out;
  assign exe_grant = r_grant;
  assign hit_left  = r_hit;

endmodule
